// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic inter-stage register with DEPTH slots, valid/ready
//               handshake, flush, bubble gating and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 35,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]  slot_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  adv;
  logic [CTRL_W-1:0] ctrl_q   [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0]  src_valid;
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];

  // A slot may advance if the output drains or any slot from it to the end is empty.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&valid_q[DEPTH-1:k]);
  end

  assign in_ready = adv[0] & ~flush;

  always_comb begin
    src_valid[0] = in_valid & in_ready;
    src_ctrl[0]  = in_ctrl;
    src_data[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = valid_q[k-1];
      src_ctrl[k]  = ctrl_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
          ctrl_q[k]  <= '0;
        end else if (adv[k]) begin
          valid_q[k] <= src_valid[k];
          ctrl_q[k]  <= src_valid[k] ? src_ctrl[k] : '0;
          // Payload holds on bubbles to avoid needless toggling downstream.
          if (src_valid[k]) begin
            data_q[k] <= src_data[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = valid_q[DEPTH-1];
  assign out_ctrl   = out_valid ? ctrl_q[DEPTH-1] : '0;
  assign out_data   = data_q[DEPTH-1];
  assign slot_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench; DEPTH 1/2/3 instances share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_ctrl;
  logic [34:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        r1_in_ready, r1_out_valid;
  logic [3:0]  r1_out_ctrl;
  logic [34:0] r1_out_data;
  logic [0:0]  r1_slot_valid;
  logic [3:0]  r1_stall_cnt;

  logic        r2_in_ready, r2_out_valid;
  logic [3:0]  r2_out_ctrl;
  logic [34:0] r2_out_data;
  logic [1:0]  r2_slot_valid;
  logic [15:0] r2_stall_cnt;

  logic        r3_in_ready, r3_out_valid;
  logic [3:0]  r3_out_ctrl;
  logic [34:0] r3_out_data;
  logic [2:0]  r3_slot_valid;
  logic [15:0] r3_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(35), .CTRL_W(4), .DEPTH(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(r1_out_valid),
    .out_ready(out_ready), .out_ctrl(r1_out_ctrl), .out_data(r1_out_data),
    .slot_valid(r1_slot_valid), .stall_cnt(r1_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(35), .CTRL_W(4), .DEPTH(2), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(r2_out_valid),
    .out_ready(out_ready), .out_ctrl(r2_out_ctrl), .out_data(r2_out_data),
    .slot_valid(r2_slot_valid), .stall_cnt(r2_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(35), .CTRL_W(4), .DEPTH(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(r3_out_valid),
    .out_ready(out_ready), .out_ctrl(r3_out_ctrl), .out_data(r3_out_data),
    .slot_valid(r3_slot_valid), .stall_cnt(r3_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset and pass-through, DEPTH=1 ----------------
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'($urandom);
    in_data   = 35'($urandom);
    out_ready = 1'($urandom);
    tick();
    tick();
    chk("rst_out_valid", 64'(r1_out_valid), 64'(0));
    chk("rst_out_ctrl",  64'(r1_out_ctrl),  64'(0));
    chk("rst_out_data",  64'(r1_out_data),  64'(0));
    chk("rst_slot_valid", 64'(r1_slot_valid), 64'(0));
    chk("rst_stall_cnt", 64'(r1_stall_cnt), 64'(0));
    chk("rst_in_ready",  64'(r1_in_ready),  64'(1));
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 4'b0101;
    in_data   = 35'h1ABCD;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pass_out_valid", 64'(r1_out_valid), 64'(1));
    chk("pass_out_ctrl",  64'(r1_out_ctrl),  64'(5));
    chk("pass_out_data",  64'(r1_out_data),  64'(35'h1ABCD));

    // ---------------- streaming, DEPTH=3 ----------------
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 10);
      in_ctrl  = 4'(i + 1);
      in_data  = 35'(100 + i);
      #1;
      chk("stream_in_ready", 64'(r3_in_ready), 64'(1));
      tick();
      if (i >= 2 && i < 12) begin
        chk("stream_out_valid", 64'(r3_out_valid), 64'(1));
        chk("stream_out_data",  64'(r3_out_data),  64'(100 + i - 2));
        chk("stream_out_ctrl",  64'(r3_out_ctrl),  64'(i - 1));
      end else begin
        chk("stream_gap_valid", 64'(r3_out_valid), 64'(0));
      end
    end

    // ---------------- stall / full, DEPTH=2 ----------------
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h3;
    in_data   = 35'h11;
    tick();
    in_data = 35'h22;
    tick();
    in_data = 35'h33;
    chk("full_in_ready", 64'(r2_in_ready), 64'(0));
    chk("full_slots",    64'(r2_slot_valid), 64'(2'b11));
    chk("full_cnt0",     64'(r2_stall_cnt), 64'(0));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("stall_cnt_step", 64'(r2_stall_cnt), 64'(i));
      chk("stall_in_ready", 64'(r2_in_ready), 64'(0));
      chk("stall_out_data", 64'(r2_out_data), 64'(35'h11));
    end
    out_ready = 1'b1;
    #1;
    chk("recover_in_ready", 64'(r2_in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("drain_b_valid", 64'(r2_out_valid), 64'(1));
    chk("drain_b_data",  64'(r2_out_data),  64'(35'h22));
    chk("drain_cnt_hold", 64'(r2_stall_cnt), 64'(3));
    tick();
    chk("drain_c_valid", 64'(r2_out_valid), 64'(1));
    chk("drain_c_data",  64'(r2_out_data),  64'(35'h33));
    tick();
    chk("drain_empty", 64'(r2_out_valid), 64'(0));

    // ---------------- flush, DEPTH=3 ----------------
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      in_data = 35'(12'h200 + i);
      tick();
    end
    chk("pre_flush_slots", 64'(r3_slot_valid), 64'(3'b111));
    chk("pre_flush_ready", 64'(r3_in_ready), 64'(0));
    flush     = 1'b1;
    in_data   = 35'h3FF;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 64'(r3_in_ready), 64'(0));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_slots",    64'(r3_slot_valid), 64'(0));
    chk("flush_out_ctrl", 64'(r3_out_ctrl), 64'(0));
    chk("flush_data_hold", 64'(r3_out_data), 64'(35'h201));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_leak", 64'(r3_out_valid), 64'(0));
    end

    // ---------------- bubble gating, DEPTH=3 ----------------
    do_reset();
    out_ready = 1'b1;
    in_ctrl   = 4'b1111;
    in_valid  = 1'b1; in_data = 35'hA1; tick();
    in_valid  = 1'b0; in_data = 35'hA2; tick();
    in_valid  = 1'b1; in_data = 35'hA3; tick();
    in_valid  = 1'b0;
    chk("bub0_ctrl", 64'(r3_out_ctrl), 64'(4'hF));
    chk("bub0_data", 64'(r3_out_data), 64'(35'hA1));
    tick();
    chk("bub1_ctrl",  64'(r3_out_ctrl),  64'(0));
    chk("bub1_valid", 64'(r3_out_valid), 64'(0));
    chk("bub1_data",  64'(r3_out_data),  64'(35'hA1));
    tick();
    chk("bub2_ctrl", 64'(r3_out_ctrl), 64'(4'hF));
    chk("bub2_data", 64'(r3_out_data), 64'(35'hA3));

    // ---------------- stall counter saturation, DEPTH=1 CNT_W=4 ----------------
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h6;
    in_data   = 35'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15 || i == 16) chk("sat_reach", 64'(r1_stall_cnt), 64'(15));
    end
    chk("sat_hold",  64'(r1_stall_cnt), 64'(15));
    chk("sat_valid", 64'(r1_out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_cnt",   64'(r1_stall_cnt), 64'(0));
    chk("async_valid", 64'(r1_out_valid), 64'(0));
    chk("async_ctrl",  64'(r1_out_ctrl),  64'(0));
    tick();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
